// File: rtl/taxi_eth_sched_pkg.sv
// Shared types and constants for the MAC TX packet scheduler.
package taxi_eth_sched_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } sched_state_t;

   localparam int CNT_W = 4;

endpackage

// File: rtl/taxi_rr_arb.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping at PORTS-1.
module taxi_rr_arb #(
   parameter int PORTS = 4,
   parameter int IDX_W = 2
) (
   input  logic [PORTS-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [PORTS-1:0] gnt_oh,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_vld
);

   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] cand;

   always_comb begin
      gnt_oh  = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      sum     = '0;
      cand    = '0;
      for (int i = 0; i < PORTS; i++) begin
         // one extra bit so ptr+i cannot overflow before the modulo fold
         sum = {1'b0, ptr} + (IDX_W+1)'(i);
         if (sum >= (IDX_W+1)'(PORTS)) sum = sum - (IDX_W+1)'(PORTS);
         cand = sum[IDX_W-1:0];
         if (!gnt_vld && req[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
      gnt_oh[gnt_idx] = gnt_vld;
   end

endmodule

// File: rtl/taxi_eth_mac_tx_sched.sv
// Packet-granular round-robin scheduler in front of one MAC TX sink; tags tid with the
// source port, routes completions back and limits in-flight packets per port.
module taxi_eth_mac_tx_sched
   import taxi_eth_sched_pkg::*;
#(
   parameter int PORTS   = 4,
   parameter int DATA_W  = 64,
   parameter int KEEP_W  = 8,
   parameter int USER_W  = 1,
   parameter int ID_W    = 8,
   parameter int MAX_OUT = 4
) (
   input  logic                      tx_clk,
   input  logic                      tx_rst_n,
   input  logic                      cfg_enable,
   input  logic [PORTS*DATA_W-1:0]   s_axis_tdata,
   input  logic [PORTS*KEEP_W-1:0]   s_axis_tkeep,
   input  logic [PORTS-1:0]          s_axis_tvalid,
   output logic [PORTS-1:0]          s_axis_tready,
   input  logic [PORTS-1:0]          s_axis_tlast,
   input  logic [PORTS*USER_W-1:0]   s_axis_tuser,
   output logic [DATA_W-1:0]         m_axis_tx_tdata,
   output logic [KEEP_W-1:0]         m_axis_tx_tkeep,
   output logic                      m_axis_tx_tvalid,
   input  logic                      m_axis_tx_tready,
   output logic                      m_axis_tx_tlast,
   output logic [USER_W-1:0]         m_axis_tx_tuser,
   output logic [ID_W-1:0]           m_axis_tx_tid,
   input  logic                      s_axis_cpl_tvalid,
   input  logic [ID_W-1:0]           s_axis_cpl_tid,
   output logic                      s_axis_cpl_tready,
   output logic [PORTS-1:0]          cpl_valid,
   output logic [PORTS*CNT_W-1:0]    stat_outstanding,
   output logic                      stat_cpl_err
);

   localparam int IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1;

   logic [PORTS-1:0][DATA_W-1:0] tdata_a;
   logic [PORTS-1:0][KEEP_W-1:0] tkeep_a;
   logic [PORTS-1:0][USER_W-1:0] tuser_a;

   assign tdata_a = s_axis_tdata;
   assign tkeep_a = s_axis_tkeep;
   assign tuser_a = s_axis_tuser;

   sched_state_t                state_q, state_d;
   logic [IDX_W-1:0]            grant_q, grant_d;
   logic [IDX_W-1:0]            ptr_q, ptr_d;
   logic [PORTS-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [PORTS-1:0]            cpl_vld_q, cpl_vld_d;
   logic                        cpl_err_q, cpl_err_d;
   logic                        cpl_rdy_q;

   logic [PORTS-1:0]            elig;
   logic [PORTS-1:0]            arb_oh;
   logic [IDX_W-1:0]            arb_idx;
   logic                        arb_vld;
   logic                        xfer, beat, take;
   logic                        cpl_take, cpl_hit;
   logic [IDX_W-1:0]            cpl_idx;

   // the in-flight cap is what keeps the 4-bit counters from ever wrapping
   always_comb begin
      elig = '0;
      for (int p = 0; p < PORTS; p++)
         elig[p] = s_axis_tvalid[p] & (cnt_q[p] < CNT_W'(MAX_OUT)) & cfg_enable;
   end

   taxi_rr_arb #(
      .PORTS (PORTS),
      .IDX_W (IDX_W)
   ) u_arb (
      .req     (elig),
      .ptr     (ptr_q),
      .gnt_oh  (arb_oh),
      .gnt_idx (arb_idx),
      .gnt_vld (arb_vld)
   );

   // datapath is a pure mux on the registered grant, so tid holds for the whole packet
   assign xfer             = (state_q == ST_XFER);
   assign m_axis_tx_tdata  = tdata_a[grant_q];
   assign m_axis_tx_tkeep  = tkeep_a[grant_q];
   assign m_axis_tx_tuser  = tuser_a[grant_q];
   assign m_axis_tx_tlast  = s_axis_tlast[grant_q];
   assign m_axis_tx_tvalid = xfer & s_axis_tvalid[grant_q];
   assign m_axis_tx_tid    = ID_W'(grant_q);
   assign beat             = m_axis_tx_tvalid & m_axis_tx_tready;

   always_comb begin
      s_axis_tready = '0;
      if (xfer) s_axis_tready[grant_q] = m_axis_tx_tready;
   end

   assign cpl_idx  = s_axis_cpl_tid[IDX_W-1:0];
   assign cpl_take = s_axis_cpl_tvalid & cpl_rdy_q;
   assign cpl_hit  = cpl_take & (s_axis_cpl_tid < ID_W'(PORTS)) & (cnt_q[cpl_idx] != '0);

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      cpl_vld_d = '0;
      cpl_err_d = cpl_err_q;
      take      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (arb_vld) begin
               take    = 1'b1;
               grant_d = arb_idx;
               state_d = ST_XFER;
            end
         end
         ST_XFER: begin
            if (beat && m_axis_tx_tlast) begin
               ptr_d   = (grant_q == IDX_W'(PORTS-1)) ? '0 : grant_q + 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (cpl_hit) cpl_vld_d[cpl_idx] = 1'b1;
      if (cpl_take && !cpl_hit) cpl_err_d = 1'b1;
      // a grant and a completion on the same port in one cycle cancel out
      for (int p = 0; p < PORTS; p++) begin
         if (take && arb_oh[p] && !cpl_vld_d[p])
            cnt_d[p] = cnt_q[p] + 1'b1;
         else if (!(take && arb_oh[p]) && cpl_vld_d[p])
            cnt_d[p] = cnt_q[p] - 1'b1;
      end
   end

   always_ff @(posedge tx_clk or negedge tx_rst_n) begin
      if (!tx_rst_n) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         ptr_q     <= '0;
         cnt_q     <= '0;
         cpl_vld_q <= '0;
         cpl_err_q <= 1'b0;
         cpl_rdy_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         cpl_vld_q <= cpl_vld_d;
         cpl_err_q <= cpl_err_d;
         cpl_rdy_q <= 1'b1;
      end
   end

   assign s_axis_cpl_tready = cpl_rdy_q;
   assign cpl_valid         = cpl_vld_q;
   assign stat_outstanding  = cnt_q;
   assign stat_cpl_err      = cpl_err_q;

endmodule
